// File: rtl/spi_rd_arbiter_pkg.sv
// Shared constants and width helpers for the SPI read arbiter.
// FSM encodings stay as plain 2-bit constants so they match older code that uses the same values.
package spi_rd_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int timeout_cyc, input int gap_cycles);
        return $clog2((timeout_cyc > gap_cycles) ? timeout_cyc : gap_cycles) + 1;
    endfunction

endpackage

// File: rtl/spi_rd_arbiter_if.sv
// Client request/ack bus plus the shared SPI read-engine control lines.
// The arbiter uses the master modport; the clients and the engine use the slave modport.
interface spi_rd_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 16,
    parameter int ID_W   = 1
);
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ID_W-1:0]   rd_id;
    logic              timeout;
    logic              eng_start;
    logic [N_REQ-1:0]  eng_cs_sel;
    logic              eng_done;
    logic [DATA_W-1:0] eng_data;

    modport master (
        input  req, eng_done, eng_data,
        output ack, rd_data, rd_valid, rd_id, timeout, eng_start, eng_cs_sel
    );

    modport slave (
        output req, eng_done, eng_data,
        input  ack, rd_data, rd_valid, rd_id, timeout, eng_start, eng_cs_sel
    );
endinterface

// File: rtl/spi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting id after last_grant.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic             any,
    output logic [ID_W-1:0]  grant_id
);

    // Scan from the farthest candidate down to last_grant+1, so the nearest requester wins.
    always_comb begin
        any      = |req;
        grant_id = last_grant;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[(int'(last_grant) + i) % N_REQ]) begin
                grant_id = ID_W'((int'(last_grant) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/spi_rd_arbiter.sv
// Round-robin arbiter that shares one SPI read engine between N_REQ clients.
// It sequences start, chip-select, capture and ack, then holds CS high for a gap and applies a watchdog.
module spi_rd_arbiter
    import spi_rd_arbiter_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    spi_rd_arbiter_if.master    bus
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT_CYC, GAP_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   rd_id_q, rd_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  cs_sel_q, cs_sel_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              timeout_q, timeout_d;
    logic              eng_start_q, eng_start_d;
    logic              pick_any;
    logic [ID_W-1:0]   pick_id;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req        (bus.req),
        .last_grant (last_grant_q),
        .any        (pick_any),
        .grant_id   (pick_id)
    );

    // cnt counts clocks since eng_start while reading, and gap clocks while in GAP.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        rd_id_d      = rd_id_q;
        cnt_d        = cnt_q;
        cs_sel_d     = cs_sel_q;
        rd_data_d    = rd_data_q;
        ack_d        = '0;
        rd_valid_d   = 1'b0;
        timeout_d    = 1'b0;
        eng_start_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_id_d  = pick_id;
                    eng_start_d = 1'b1;
                    cs_sel_d    = onehot(pick_id);
                    cnt_d       = '0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A completion in the same cycle as the watchdog limit counts as a good read.
                if (bus.eng_done) begin
                    rd_data_d    = bus.eng_data;
                    rd_id_d      = grant_id_q;
                    rd_valid_d   = 1'b1;
                    ack_d        = onehot(grant_id_q);
                    last_grant_d = grant_id_q;
                    cs_sel_d     = '0;
                    cnt_d        = '0;
                    state_d      = ST_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_d    = 1'b1;
                    ack_d        = onehot(grant_id_q);
                    last_grant_d = grant_id_q;
                    cs_sel_d     = '0;
                    cnt_d        = '0;
                    state_d      = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            rd_id_q      <= '0;
            cnt_q        <= '0;
            cs_sel_q     <= '0;
            rd_data_q    <= '0;
            ack_q        <= '0;
            rd_valid_q   <= 1'b0;
            timeout_q    <= 1'b0;
            eng_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            rd_id_q      <= rd_id_d;
            cnt_q        <= cnt_d;
            cs_sel_q     <= cs_sel_d;
            rd_data_q    <= rd_data_d;
            ack_q        <= ack_d;
            rd_valid_q   <= rd_valid_d;
            timeout_q    <= timeout_d;
            eng_start_q  <= eng_start_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_id      = rd_id_q;
    assign bus.timeout    = timeout_q;
    assign bus.eng_start  = eng_start_q;
    assign bus.eng_cs_sel = cs_sel_q;

endmodule
